// File: rtl/attocore_pkg.sv
// Shared definitions for the attocore_p CPU: opcodes, FSM states and special register indices.
package attocore_pkg;

  localparam int unsigned IR_W  = 8;
  localparam int unsigned REG_N = 16;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_JMP = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_LOG = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_MEM = 3'd6;
  localparam logic [2:0] OP_SYS = 3'd7;

  typedef enum logic [2:0] {FETCH, DECODE, MEM, IMM, HALT} state_t;

  localparam logic [3:0] R_ADDR_LO = 4'd0;
  localparam logic [3:0] R_ADDR_HI = 4'd1;
  localparam logic [3:0] R_PC_LO   = 4'd2;
  localparam logic [3:0] R_PC_HI   = 4'd3;
  localparam logic [3:0] R_IR      = 4'd4;
  localparam logic [3:0] R_A       = 4'd5;
  localparam logic [3:0] R_Y       = 4'd7;

endpackage

// File: rtl/attocore_alu.sv
// Combinational ALU for ops 2-4: result Y plus zero and carry/borrow/shift-out flags.
module attocore_alu
  import attocore_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  input  logic              m,
  output logic [DATA_W-1:0] y,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    y   = '0;
    c   = 1'b0;
    case (op)
      OP_ADD: begin
        if (m) begin
          y = a - b;
          c = (a < b);
        end else begin
          y = sum[DATA_W-1:0];
          c = sum[DATA_W];
        end
      end
      OP_LOG: y = m ? (a | b) : (a & b);
      OP_XOR: begin
        if (m) begin
          y = b >> 1;
          c = b[0];
        end else begin
          y = a ^ b;
        end
      end
      default: ;
    endcase
  end

  assign z = (y == '0);

endmodule

// File: rtl/attocore_p.sv
// Multi-cycle accumulator CPU: fetch/decode FSM, register file and req/ack memory bus driver.
module attocore_p
  import attocore_pkg::*;
#(
  parameter int unsigned     DATA_W   = 8,
  parameter int unsigned     ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_dir,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              halted
);

  localparam int unsigned PW = 2 * DATA_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc, addr_reg, addr_d;
  logic [IR_W-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0]   rf [REG_N];
  logic                z_q, z_d, c_q, c_d, halted_d, req_d, dir_d;
  logic [DATA_W-1:0]   dout_d, rn, wr_data, alu_y;
  logic                wr_en, alu_z, alu_c;
  logic [3:0]          wr_idx;
  logic [PW-1:0]       pc_ext;
  logic [2:0]          op;
  logic                m;
  logic [3:0]          n;

  assign op       = ir_q[7:5];
  assign m        = ir_q[4];
  assign n        = ir_q[3:0];
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign addr_reg = ADDR_W'({rf[R_ADDR_HI], rf[R_ADDR_LO]});
  assign pc_ext   = PW'(pc_q);

  // r2..r4 are read-only views of pc and ir
  always_comb begin
    case (n)
      R_PC_LO: rn = pc_ext[DATA_W-1:0];
      R_PC_HI: rn = pc_ext[PW-1:DATA_W];
      R_IR:    rn = DATA_W'(ir_q);
      default: rn = rf[n];
    endcase
  end

  attocore_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (rf[R_A]),
    .b  (rn),
    .op (op),
    .m  (m),
    .y  (alu_y),
    .z  (alu_z),
    .c  (alu_c)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_d      = z_q;
    c_d      = c_q;
    halted_d = halted;
    req_d    = mem_req;
    addr_d   = address_bus;
    dout_d   = data_out;
    dir_d    = data_dir;
    wr_en    = 1'b0;
    wr_idx   = n;
    wr_data  = alu_y;
    case (state_q)
      FETCH: begin
        // entered idle after reset or a MEM/IMM access: raise the request one cycle later
        if (!mem_req) begin
          req_d  = 1'b1;
          addr_d = pc_q;
          dir_d  = 1'b1;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          ir_d    = data_in[IR_W-1:0];
          state_d = DECODE;
        end
      end
      DECODE: begin
        pc_d    = pc_inc;
        state_d = FETCH;
        case (op)
          OP_JMP: if (!m || z_q) pc_d = addr_reg;
          OP_ADD, OP_LOG, OP_XOR: begin
            wr_en   = 1'b1;
            wr_idx  = R_Y;
            wr_data = alu_y;
            z_d     = alu_z;
            c_d     = alu_c;
          end
          OP_MOV: begin
            wr_en   = 1'b1;
            wr_idx  = m ? n : R_A;
            wr_data = m ? rf[R_Y] : rn;
          end
          OP_MEM: begin
            state_d = MEM;
            req_d   = 1'b1;
            addr_d  = addr_reg;
            dir_d   = !m;
            dout_d  = m ? rn : '0;
          end
          OP_SYS: begin
            if (m) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end else begin
              state_d = IMM;
              req_d   = 1'b1;
              addr_d  = pc_inc;
              dir_d   = 1'b1;
            end
          end
          default: ;
        endcase
        // back-to-back fetch: DECODE itself provides the idle cycle
        if (state_d == FETCH) begin
          req_d  = 1'b1;
          addr_d = pc_d;
          dir_d  = 1'b1;
        end
      end
      MEM: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          dir_d   = 1'b1;
          state_d = FETCH;
          if (data_dir) begin
            wr_en   = 1'b1;
            wr_data = data_in;
          end
        end
      end
      IMM: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          pc_d    = pc_inc;
          state_d = FETCH;
          wr_en   = 1'b1;
          wr_data = data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      halted      <= 1'b0;
      mem_req     <= 1'b0;
      address_bus <= RESET_PC;
      data_out    <= '0;
      data_dir    <= 1'b1;
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      z_q         <= z_d;
      c_q         <= c_d;
      halted      <= halted_d;
      mem_req     <= req_d;
      address_bus <= addr_d;
      data_out    <= dout_d;
      data_dir    <= dir_d;
      if (wr_en && !(wr_idx inside {R_PC_LO, R_PC_HI, R_IR})) rf[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_attocore_p.sv
// Self-checking bench for attocore_p: memory responder with wait states and a bus-transaction scoreboard.
module tb_attocore_p;

  typedef struct packed {
    logic [15:0] addr;
    logic        dir;
    logic [7:0]  data;
  } txn_t;

  logic        clock, reset, reset2;
  logic [15:0] address_bus;
  logic [7:0]  data_out, data_in;
  logic        data_dir, mem_req, mem_ack, halted;
  logic [7:0]  addr2, dout2, din2;
  logic        dir2, req2, ack2, halted2;

  logic [7:0]  mem [65536];
  txn_t        obs_q[$], exp_q[$];
  int          rise_q[$];
  int          tests, fails, cycle, wait_cycles, cnt, stab_err, gap_err;
  bit          ack_block, req_prev, acked_prev;
  logic [15:0] hold_addr;
  logic        hold_dir;
  logic [7:0]  hold_dout;

  attocore_p #(.DATA_W(8), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .address_bus(address_bus), .data_out(data_out),
    .data_in(data_in), .data_dir(data_dir), .mem_req(mem_req), .mem_ack(mem_ack),
    .halted(halted)
  );

  attocore_p #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'hFF)) dut_wrap (
    .clock(clock), .reset(reset2), .address_bus(addr2), .data_out(dout2),
    .data_in(din2), .data_dir(dir2), .mem_req(req2), .mem_ack(ack2),
    .halted(halted2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cycle++;
  end

  // Memory responder: acks after wait_cycles request cycles, logs completed transactions.
  initial begin
    mem_ack = 1'b0; data_in = '0; ack2 = 1'b0; din2 = '0;
    forever begin
      @(negedge clock);
      ack2 = req2;
      if (mem_req && acked_prev) gap_err++;
      acked_prev = 1'b0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!req_prev) begin
          hold_addr = address_bus; hold_dir = data_dir; hold_dout = data_out;
          cnt = 0;
          rise_q.push_back(cycle);
        end else if (address_bus !== hold_addr || data_dir !== hold_dir || data_out !== hold_dout) begin
          stab_err++;
        end
        if (!ack_block && cnt >= wait_cycles) begin
          mem_ack = 1'b1;
          acked_prev = 1'b1;
          if (data_dir) begin
            data_in = mem[address_bus];
            obs_q.push_back(txn_t'{address_bus, 1'b1, mem[address_bus]});
          end else begin
            mem[address_bus] = data_out;
            obs_q.push_back(txn_t'{address_bus, 1'b0, data_out});
          end
        end
        cnt++;
      end
      req_prev = mem_req;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    exp_q.delete();
  endtask

  task automatic run_prog(input int wcyc, output bit ok);
    wait_cycles = wcyc;
    ack_block = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    obs_q.delete(); rise_q.delete();
    stab_err = 0; gap_err = 0;
    reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #1;
      if (halted) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if ({address_bus, data_out, data_dir, mem_req, halted} !== {16'h0000, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs got addr=%h dout=%h dir=%b req=%b halt=%b want 0000 00 1 0 0",
               address_bus, data_out, data_dir, mem_req, halted);
    end
    tests++;
    if ({dut.pc_q, dut.rf[5], dut.rf[7], dut.z_q, dut.c_q} !== {16'h0000, 8'h00, 8'h00, 2'b00}) begin
      fails++;
      $display("FAIL reset_state got pc=%h a=%h y=%h z=%b c=%b want all zero",
               dut.pc_q, dut.rf[5], dut.rf[7], dut.z_q, dut.c_q);
    end
    ack_block = 1'b1;
    reset = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (mem_req !== 1'b1 || address_bus !== 16'h0000 || data_dir !== 1'b1) begin
      fails++;
      $display("FAIL first_fetch got req=%b addr=%h dir=%b want 1 0000 1", mem_req, address_bus, data_dir);
    end
    ack_block = 1'b0;
  endtask

  task automatic test_prog1(input int wcyc);
    logic [7:0] p [6] = '{8'hE5, 8'h0F, 8'hE8, 8'hF1, 8'h48, 8'hF0};
    txn_t e, o;
    bit ok;
    clear_mem();
    for (int i = 0; i < 6; i++) begin
      mem[i] = p[i];
      exp_q.push_back(txn_t'{16'(i), 1'b1, p[i]});
    end
    run_prog(wcyc, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL prog1_halt_timeout wait=%0d got halted=%b want 1", wcyc, halted); end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL prog1_txn_count wait=%0d got %0d want %0d", wcyc, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL prog1_txn got %h want %h", o, e); end
    end
    tests++;
    if ({dut.rf[7], dut.z_q, dut.c_q, dut.rf[5], dut.rf[8], dut.pc_q} !== {8'h00, 1'b1, 1'b1, 8'h0F, 8'hF1, 16'h0006}) begin
      fails++;
      $display("FAIL prog1_regs wait=%0d got y=%h z=%b c=%b a=%h r8=%h pc=%h want 00 1 1 0f f1 0006",
               wcyc, dut.rf[7], dut.z_q, dut.c_q, dut.rf[5], dut.rf[8], dut.pc_q);
    end
    repeat (5) @(posedge clock);
    #1;
    tests++;
    if (mem_req !== 1'b0 || halted !== 1'b1 || obs_q.size() != 0) begin
      fails++; $display("FAIL prog1_halt_sticky got req=%b halted=%b extra=%0d want 0 1 0", mem_req, halted, obs_q.size());
    end
    tests++;
    if (stab_err != 0 || gap_err != 0) begin
      fails++; $display("FAIL prog1_handshake wait=%0d got stab=%0d gap=%0d want 0 0", wcyc, stab_err, gap_err);
    end
  endtask

  task automatic test_jz();
    logic [7:0] p [10] = '{8'hE0, 8'h40, 8'hE1, 8'h00, 8'hE5, 8'h03, 8'hE6, 8'h03, 8'h56, 8'h30};
    txn_t e, o;
    bit ok;
    clear_mem();
    for (int i = 0; i < 10; i++) begin
      mem[i] = p[i];
      exp_q.push_back(txn_t'{16'(i), 1'b1, p[i]});
    end
    mem[16'h0040] = 8'hF0;
    exp_q.push_back(txn_t'{16'h0040, 1'b1, 8'hF0});
    run_prog(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL jz_halt_timeout got halted=%b want 1", halted); end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL jz_txn_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL jz_txn got %h want %h", o, e); end
    end
    tests++;
    if ({dut.pc_q, dut.rf[7], dut.z_q, dut.c_q} !== {16'h0041, 8'h00, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL jz_regs got pc=%h y=%h z=%b c=%b want 0041 00 1 0", dut.pc_q, dut.rf[7], dut.z_q, dut.c_q);
    end
  endtask

  task automatic test_nop_timing(input int wcyc, input int want);
    bit ok;
    clear_mem();
    mem[2] = 8'hF0;
    run_prog(wcyc, ok);
    tests++;
    if (!ok || rise_q.size() < 3) begin
      fails++; $display("FAIL nop_timing_run wait=%0d got halted=%b rises=%0d want 1 3", wcyc, halted, rise_q.size());
    end else if (rise_q[1] - rise_q[0] != want) begin
      fails++; $display("FAIL nop_timing wait=%0d got %0d cycles want %0d", wcyc, rise_q[1] - rise_q[0], want);
    end
  endtask

  task automatic test_store_load();
    logic [7:0] p [9] = '{8'hE0, 8'h34, 8'hE1, 8'h12, 8'hE9, 8'hA5, 8'hD9, 8'hC8, 8'hF0};
    txn_t e, o;
    bit ok;
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = p[i];
    for (int i = 0; i < 7; i++) exp_q.push_back(txn_t'{16'(i), 1'b1, p[i]});
    exp_q.push_back(txn_t'{16'h1234, 1'b0, 8'hA5});
    exp_q.push_back(txn_t'{16'h0007, 1'b1, 8'hC8});
    exp_q.push_back(txn_t'{16'h1234, 1'b1, 8'hA5});
    exp_q.push_back(txn_t'{16'h0008, 1'b1, 8'hF0});
    run_prog(1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stld_halt_timeout got halted=%b want 1", halted); end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL stld_txn_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL stld_txn got %h want %h", o, e); end
    end
    tests++;
    if (dut.rf[8] !== 8'hA5 || stab_err != 0) begin
      fails++; $display("FAIL stld_r8 got r8=%h stab=%0d want a5 0", dut.rf[8], stab_err);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_mem();
    wait_cycles = 0;
    ack_block = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if (mem_req !== 1'b1) begin fails++; $display("FAIL midrst_pending got req=%b want 1", mem_req); end
    reset = 1'b1;
    @(posedge clock); #1;
    tests++;
    if ({address_bus, data_out, data_dir, mem_req, halted} !== {16'h0000, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midrst_outputs got addr=%h dout=%h dir=%b req=%b halt=%b want 0000 00 1 0 0",
               address_bus, data_out, data_dir, mem_req, halted);
    end
    reset = 1'b0;
    obs_q.delete();
    ack_block = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (mem_req !== 1'b1 || address_bus !== 16'h0000) begin
      fails++; $display("FAIL midrst_refetch got req=%b addr=%h want 1 0000", mem_req, address_bus);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clock); #1;
      seen = (obs_q.size() > 0);
    end
    tests++;
    if (!seen || obs_q[0] !== txn_t'{16'h0000, 1'b1, 8'h00}) begin
      fails++; $display("FAIL midrst_first_txn got seen=%b txn=%h want 1 %h", seen,
                        seen ? obs_q[0] : txn_t'('0), txn_t'{16'h0000, 1'b1, 8'h00});
    end
  endtask

  task automatic test_pc_wrap();
    logic [7:0] a [2];
    int k;
    bit prev;
    reset2 = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset2 = 1'b0;
    k = 0; prev = 1'b0;
    for (int i = 0; i < 40 && k < 2; i++) begin
      @(negedge clock);
      if (req2 && !prev) begin a[k] = addr2; k++; end
      prev = req2;
    end
    tests++;
    if (k != 2) begin
      fails++; $display("FAIL wrap_fetches got %0d want 2", k);
    end else begin
      tests++;
      if (a[0] !== 8'hFF || a[1] !== 8'h00) begin
        fails++; $display("FAIL wrap_addr got %h,%h want ff,00", a[0], a[1]);
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; cycle = 0; wait_cycles = 0; cnt = 0;
    stab_err = 0; gap_err = 0; ack_block = 1'b0; req_prev = 1'b0; acked_prev = 1'b0;
    reset = 1'b1; reset2 = 1'b1;
    test_reset();
    test_prog1(0);
    test_jz();
    test_prog1(3);
    test_nop_timing(0, 2);
    test_nop_timing(3, 5);
    test_store_load();
    test_reset_mid();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
